// File: rtl/flag_evt_pkg.sv
// flag_evt_pkg
//   Shared types and defaults for the flag event queue.
//   evt_state_t  : queue occupancy state (IDLE / PEND / FULL)
//   CNT_W_DEF    : default pending-counter width
//   TMO_CYC_DEF  : default watchdog timeout in cycles
package flag_evt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      FULL = 2'd2
   } evt_state_t;

   localparam int CNT_W_DEF   = 4;
   localparam int TMO_CYC_DEF = 255;

endpackage

// File: rtl/flag_evt_tmo.sv
// flag_evt_tmo
//   Watchdog for a stalled evt_valid/evt_ready handshake. A down-counter is
//   armed with TMO_CYC and decrements every cycle the event is offered but not
//   taken; at terminal count tmo pulses for one cycle and the counter re-arms.
//   Any acceptance or an empty queue re-arms the counter. Observes only; it
//   never touches queue state.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   evt_valid  in   queue is offering an event
//   evt_ready  in   consumer ready
//   tmo        out  one-cycle timeout pulse (registered)
module flag_evt_tmo #(
   parameter int TMO_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic evt_valid,
   input  logic evt_ready,
   output logic tmo
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC);

   logic [TMO_W-1:0] remain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain <= TMO_LOAD;
         tmo    <= 1'b0;
      end else begin
         tmo <= 1'b0;
         if (evt_valid && !evt_ready) begin
            if (remain == TMO_W'(1)) begin
               tmo    <= 1'b1;
               remain <= TMO_LOAD;
            end else begin
               remain <= remain - TMO_W'(1);
            end
         end else begin
            remain <= TMO_LOAD;
         end
      end
   end

endmodule

// File: rtl/flag_evt_queue.sv
// flag_evt_queue
//   Destination-domain consumer of single-cycle flag pulses. Pending events are
//   counted (saturating at 2^CNT_W-1) and offered one at a time on a
//   valid/ready handshake. A pulse arriving while full is dropped and latched
//   in the sticky ovf flag.
//   Optional watchdog enabled by macro FLAG_EVT_TIMEOUT_EN.
// Ports:
//   clk        in   destination clock
//   rst_n      in   asynchronous active-low reset
//   flag_i     in   one-cycle event pulse
//   evt_valid  out  at least one event pending (registered)
//   evt_ready  in   consumer accepts one event when high with evt_valid
//   pending    out  pending event count (registered)
//   ovf        out  sticky overflow
//   ovf_clr    in   clears ovf (a coincident overflow wins)
//   tmo        out  watchdog timeout pulse (0 without FLAG_EVT_TIMEOUT_EN)
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no event pending, evt_valid low
// PEND  | 1 .. max-1 events pending
// FULL  | counter at max; an unmatched flag_i is dropped
module flag_evt_queue
   import flag_evt_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_i,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] pending,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic             tmo
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   evt_state_t       state;
   evt_state_t       state_nxt;
   logic [CNT_W-1:0] pend_nxt;
   logic             acc;
   logic             drop;

   assign acc  = evt_valid & evt_ready;
   // Only an unmatched pulse at max is lost; with an acceptance the count
   // simply holds.
   assign drop = flag_i & ~acc & (pending == PEND_MAX);

   always_comb begin
      pend_nxt = pending;
      if (flag_i && !acc && !drop)
         pend_nxt = pending + CNT_W'(1);
      else if (!flag_i && acc)
         pend_nxt = pending - CNT_W'(1);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (flag_i) state_nxt = (pend_nxt == PEND_MAX) ? FULL : PEND;
         PEND: begin
            if (pend_nxt == PEND_MAX)
               state_nxt = FULL;
            else if (pend_nxt == '0)
               state_nxt = IDLE;
         end
         FULL: if (acc && !flag_i) state_nxt = (pend_nxt == '0) ? IDLE : PEND;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         evt_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pend_nxt;
         evt_valid <= (state_nxt != IDLE);
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

`ifdef FLAG_EVT_TIMEOUT_EN
   flag_evt_tmo #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .tmo       (tmo)
   );
`else
   // Timeout length is accepted but has no effect in this build.
   logic [31:0] unused_tmo_cyc;
   assign unused_tmo_cyc = TMO_CYC;
   assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_flag_evt_queue.sv
// tb_flag_evt_queue
//   Directed and randomized stimulus against a count-based reference model of
//   the event queue; outputs are compared every cycle.
module tb_flag_evt_queue;
   import flag_evt_pkg::*;

   localparam int CNT_W   = 4;
   localparam int TMO_CYC = 10;
   localparam int MAXV    = (1 << CNT_W) - 1;
`ifdef FLAG_EVT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flag_i = 1'b0;
   logic             evt_ready = 1'b0;
   logic             ovf_clr = 1'b0;
   logic             evt_valid;
   logic [CNT_W-1:0] pending;
   logic             ovf;
   logic             tmo;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int m_pend = 0;
   bit m_ovf  = 0;
   bit m_tmo  = 0;
   int m_wd   = 0;

   flag_evt_queue #(.CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flag_i    (flag_i),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .tmo       (tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pend = 0; m_ovf = 0; m_tmo = 0; m_wd = 0;
   endfunction

   // One clock of the queue rules applied to the model.
   function automatic void model_cycle(input bit f, input bit r, input bit c);
      bit v   = (m_pend != 0);
      bit acc = v && r;
      bit lost = 0;
      if (f && !acc) begin
         if (m_pend == MAXV) lost = 1;
         else m_pend++;
      end else if (!f && acc) begin
         m_pend--;
      end
      if (lost) m_ovf = 1;
      else if (c) m_ovf = 0;
      m_tmo = 0;
      if (TMO_EN) begin
         if (v && !r) begin
            m_wd++;
            if (m_wd == TMO_CYC) begin
               m_tmo = 1;
               m_wd  = 0;
            end
         end else begin
            m_wd = 0;
         end
      end
   endfunction

   task automatic compare_all();
      chk("pending", int'(pending), m_pend);
      chk("evt_valid", int'(evt_valid), int'(m_pend != 0));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("tmo", int'(tmo), int'(m_tmo));
   endtask

   task automatic step(input bit f, input bit r, input bit c);
      @(negedge clk);
      flag_i = f; evt_ready = r; ovf_clr = c;
      model_cycle(f, r, c);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic async_reset();
      @(negedge clk);
      flag_i = 0; evt_ready = 0; ovf_clr = 0;
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("rst_pending", int'(pending), 0);
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_tmo", int'(tmo), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int n_acc;
      int p;

      async_reset();

      // single event, then one acceptance
      step(1, 0, 0);
      chk("single_pending", int'(pending), 1);
      chk("single_valid", int'(evt_valid), 1);
      step(0, 1, 0);
      chk("single_drain_pending", int'(pending), 0);
      chk("single_drain_valid", int'(evt_valid), 0);

      // ready while idle is ignored
      step(0, 1, 0);
      chk("idle_ready_pending", int'(pending), 0);

      // five back-to-back pulses, then drain
      repeat (5) step(1, 0, 0);
      chk("burst5_pending", int'(pending), 5);
      chk("burst5_ovf", int'(ovf), 0);
      n_acc = 0;
      for (int i = 0; i < 20 && evt_valid; i++) begin
         n_acc++;
         step(0, 1, 0);
      end
      chk("burst5_accepts", n_acc, 5);
      chk("burst5_valid_end", int'(evt_valid), 0);

      // simultaneous flag and acceptance holds the count
      repeat (3) step(1, 0, 0);
      step(1, 1, 0);
      chk("flag_acc_pending", int'(pending), 3);
      repeat (3) step(0, 1, 0);
      chk("flag_acc_drain", int'(pending), 0);

      // saturation and overflow
      repeat (16) step(1, 0, 0);
      chk("sat_pending", int'(pending), 15);
      chk("sat_ovf", int'(ovf), 1);
      chk("sat_state_full", int'(dut.state == FULL), 1);
      step(1, 1, 0);
      chk("sat_acc_pending", int'(pending), 15);
      step(0, 0, 1);
      chk("clr_ovf", int'(ovf), 0);
      chk("clr_pending", int'(pending), 15);
      step(1, 0, 1);
      chk("clr_vs_set_ovf", int'(ovf), 1);
      step(0, 1, 0);
      chk("full_to_pend", int'(dut.state == PEND), 1);
      chk("full_to_pend_cnt", int'(pending), 14);

      // async reset mid-burst with 7 pending
      async_reset();
      repeat (7) step(1, 0, 0);
      chk("pre_rst_pending", int'(pending), 7);
      async_reset();

      // randomized traffic with varying arrival density
      for (int seg = 0; seg < 4; seg++) begin
         p = (seg == 0) ? 30 : (seg == 1) ? 80 : (seg == 2) ? 50 : 95;
         for (int i = 0; i < 150; i++)
            step($urandom_range(99) < p, $urandom_range(99) < 40, $urandom_range(99) < 8);
      end

      // watchdog: one event, consumer never ready
      async_reset();
      step(1, 0, 0);
      for (int k = 1; k <= 25; k++) begin
         step(0, 0, 0);
         chk("tmo_pulse", int'(tmo), int'(TMO_EN && (k == 10 || k == 20)));
      end
      chk("tmo_pending", int'(pending), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
